approx_mul_seq: RTL

- Parametrised sequential truncated (approximate) multiplier with a start/done handshake.
- Each operand is normalised by shifting left until its MSB is 1; the shift count is recorded.
- The top KEEP bits of each normalised operand are multiplied exactly, and the product is denormalised by right-shifting by the total shift count.
- Serves as the generic WIDTH/KEEP multiplier core for the team's approximate-arithmetic datapaths.

---
 rtl/approx_mul_seq_pkg.sv | 23 ++
 rtl/approx_mul_seq_norm_unit.sv | 45 ++++
 rtl/approx_mul_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/approx_mul_seq_pkg.sv
// Shared definitions for the approximate sequential multiplier.
//   state_t : controller state encoding
//   cnt_w   : width of a per-operand normalisation shift counter
//   rem_w   : width of the denormalisation remaining-shift counter
package approx_mul_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      NORM   = 3'd1,
      MUL    = 3'd2,
      DENORM = 3'd3,
      DONE   = 3'd4
   } state_t;

   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width);
   endfunction

   function automatic int unsigned rem_w(input int unsigned width);
      return $clog2(2 * width);
   endfunction

endpackage

// File: rtl/approx_mul_seq_norm_unit.sv
// Operand normaliser: loadable left-shift register plus shift counter.
//   clk, rst : clock, async active-low reset
//   load     : parallel load of din, clears count
//   shift    : shift left by one while the MSB is still 0
//   msb      : current MSB of the register
//   top      : leading KEEP bits of the register
//   count    : number of shifts since the last load
module norm_unit
   import approx_mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned KEEP  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic                       shift,
   input  logic [WIDTH-1:0]           din,
   output logic                       msb,
   output logic [KEEP-1:0]            top,
   output logic [cnt_w(WIDTH)-1:0]    count
);

   localparam int unsigned CW = cnt_w(WIDTH);

   logic [WIDTH-1:0] r;

   // Shift stops on its own once the leading one reaches the MSB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r     <= '0;
         count <= '0;
      end else if (load) begin
         r     <= din;
         count <= '0;
      end else if (shift && !r[WIDTH-1]) begin
         r     <= {r[WIDTH-2:0], 1'b0};
         count <= count + CW'(1);
      end
   end

   assign msb = r[WIDTH-1];
   assign top = r[WIDTH-1 -: KEEP];

endmodule

// File: rtl/approx_mul_seq.sv
// Sequential truncated multiplier: normalise, multiply leading KEEP bits, denormalise.
//   clk, rst : clock, async active-low reset
//   start    : request, sampled in IDLE only
//   x1, x2   : operands, captured on the start edge
//   busy     : high whenever not IDLE
//   done     : one-cycle pulse when out/zero update
//   out      : approximate product, held until next done
//   zero     : an operand was zero, held with out
module approx_mul_seq
   import approx_mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned KEEP  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     x1,
   input  logic [WIDTH-1:0]     x2,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   out,
   output logic                 zero
);

   localparam int unsigned CW = cnt_w(WIDTH);
   localparam int unsigned SW = rem_w(WIDTH);
   localparam int unsigned PW = 2 * KEEP;
   localparam int unsigned OW = 2 * WIDTH;

   state_t           state, state_next;
   logic [OW-1:0]    acc, acc_next, out_next;
   logic [SW-1:0]    rem, rem_next;
   logic             zero_next, done_next, busy_next;

   logic             load;
   logic             msb1, msb2;
   logic [KEEP-1:0]  top1, top2;
   logic [CW-1:0]    k1, k2;
   logic [PW-1:0]    prod;

   assign load = (state == IDLE) && start;

   norm_unit #(.WIDTH(WIDTH), .KEEP(KEEP)) u_norm1 (
      .clk(clk), .rst(rst), .load(load), .shift(state == NORM),
      .din(x1), .msb(msb1), .top(top1), .count(k1)
   );

   norm_unit #(.WIDTH(WIDTH), .KEEP(KEEP)) u_norm2 (
      .clk(clk), .rst(rst), .load(load), .shift(state == NORM),
      .din(x2), .msb(msb2), .top(top2), .count(k2)
   );

   assign prod = PW'(top1) * PW'(top2);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         acc   <= '0;
         rem   <= '0;
         out   <= '0;
         zero  <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         rem   <= rem_next;
         out   <= out_next;
         zero  <= zero_next;
         done  <= done_next;
         busy  <= busy_next;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      rem_next   = rem;
      out_next   = out;
      zero_next  = zero;

      unique case (state)
         IDLE: begin
            if (start) begin
               if (x1 == '0 || x2 == '0) begin
                  state_next = DONE;
                  out_next   = '0;
                  zero_next  = 1'b1;
               end else begin
                  state_next = NORM;
               end
            end
         end
         NORM: begin
            if (msb1 && msb2) state_next = MUL;
         end
         MUL: begin
            acc_next = OW'(prod) << (OW - PW);
            rem_next = SW'(k1) + SW'(k2);
            // Nothing to denormalise: finish straight away.
            state_next = (rem_next == '0) ? DONE : DENORM;
         end
         DENORM: begin
            if (rem != '0) begin
               acc_next = acc >> 1;
               rem_next = rem - SW'(1);
               // Last shift and DONE entry share one edge.
               if (rem == SW'(1)) state_next = DONE;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Normal-path result is captured on the edge that enters DONE.
      if (state_next == DONE && state != IDLE) begin
         out_next  = acc_next;
         zero_next = 1'b0;
      end

      done_next = (state_next == DONE);
      busy_next = (state_next != IDLE);
   end

endmodule
